// File: rtl/barrel_shifter_pkg.sv
// Shared constants and a bit-by-bit reference function for the barrel shifter.
// Setting BARREL_SHIFTER_ARITH_EN enables arithmetic right shifts in the design.
package barrel_shifter_pkg;

    localparam logic DIR_RIGHT   = 1'b0;
    localparam logic DIR_LEFT    = 1'b1;
    localparam logic MODE_SHIFT  = 1'b0;
    localparam logic MODE_ROTATE = 1'b1;

    // Each output bit is located by its source index. This is independent of the mux cascade.
    function automatic logic [31:0] ref_result(input logic [31:0] data, input int width,
                                               input int amt, input logic dir,
                                               input logic rotate, input logic arith);
        logic [31:0] result;
        logic [31:0] tmp;
        logic        b;
        int          src;
        result = '0;
        for (int i = 0; i < width; i++) begin
            src = (dir == DIR_LEFT) ? i - amt : i + amt;
            if (rotate == MODE_ROTATE) src = ((src % width) + width) % width;
            if (src >= 0 && src < width) begin
                tmp = data >> src;
                b   = tmp[0];
            end else begin
                tmp = data >> (width - 1);
                b   = arith & (dir == DIR_RIGHT) & tmp[0];
            end
            result = result | (32'(b) << i);
        end
        return result;
    endfunction

endpackage

// File: rtl/barrel_shifter_if.sv
// Operand and result bundle for the barrel shifter.
// The arith line exists only when BARREL_SHIFTER_ARITH_EN is defined.
interface barrel_shifter_if #(parameter int WIDTH = 4);
    import barrel_shifter_pkg::*;

    localparam int SHW = $clog2(WIDTH);

    logic             in_valid;
    logic [WIDTH-1:0] data_in;
    logic [SHW-1:0]   shift_amt;
    logic             dir;
    logic             rotate;
`ifdef BARREL_SHIFTER_ARITH_EN
    logic             arith;
`endif
    logic             out_valid;
    logic [WIDTH-1:0] data_out;

`ifdef BARREL_SHIFTER_ARITH_EN
    modport master (output in_valid, data_in, shift_amt, dir, rotate, arith,
                    input  out_valid, data_out);
    modport slave  (input  in_valid, data_in, shift_amt, dir, rotate, arith,
                    output out_valid, data_out);
`else
    modport master (output in_valid, data_in, shift_amt, dir, rotate,
                    input  out_valid, data_out);
    modport slave  (input  in_valid, data_in, shift_amt, dir, rotate,
                    output out_valid, data_out);
`endif

endinterface

// File: rtl/barrel_shifter_stage.sv
// Single cascade stage: shifts or rotates by a fixed DIST when enabled, otherwise passes through.
// The arith input (sign fill on right shifts) exists only when BARREL_SHIFTER_ARITH_EN is defined.
module barrel_shifter_stage
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIST  = 1
) (
    input  logic [WIDTH-1:0] word_in,
    input  logic             en,
    input  logic             dir,
    input  logic             rotate,
`ifdef BARREL_SHIFTER_ARITH_EN
    input  logic             arith,
`endif
    output logic [WIDTH-1:0] word_out
);

    logic [DIST-1:0] fill;

    // The MSB stays the sign bit through every stage, so each stage can sign-fill on its own.
    always_comb begin
        fill = '0;
`ifdef BARREL_SHIFTER_ARITH_EN
        if (arith) fill = {DIST{word_in[WIDTH-1]}};
`endif
        word_out = word_in;
        if (en) begin
            if (dir == DIR_LEFT) begin
                if (rotate == MODE_ROTATE)
                    word_out = {word_in[WIDTH-DIST-1:0], word_in[WIDTH-1:WIDTH-DIST]};
                else
                    word_out = {word_in[WIDTH-DIST-1:0], {DIST{1'b0}}};
            end else begin
                if (rotate == MODE_ROTATE)
                    word_out = {word_in[DIST-1:0], word_in[WIDTH-1:DIST]};
                else
                    word_out = {fill, word_in[WIDTH-1:DIST]};
            end
        end
    end

endmodule

// File: rtl/barrel_shifter.sv
// Logarithmic barrel shifter: one mux stage per bit of shift_amt, followed by the output register.
// Defining BARREL_SHIFTER_ARITH_EN adds arithmetic right shifts via the interface arith line.
module barrel_shifter
    import barrel_shifter_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    barrel_shifter_if.slave   bus
);

    localparam int SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] stage_word [SHW+1];
    logic [WIDTH-1:0] data_out_d, data_out_q;
    logic             out_valid_d, out_valid_q;

    assign stage_word[0] = bus.data_in;

    for (genvar s = 0; s < SHW; s++) begin : g_stage
        barrel_shifter_stage #(
            .WIDTH (WIDTH),
            .DIST  (1 << s)
        ) u_stage (
            .word_in  (stage_word[s]),
            .en       (bus.shift_amt[s]),
            .dir      (bus.dir),
            .rotate   (bus.rotate),
`ifdef BARREL_SHIFTER_ARITH_EN
            .arith    (bus.arith),
`endif
            .word_out (stage_word[s+1])
        );
    end

    // data_out keeps its last result across invalid cycles. Only out_valid drops.
    always_comb begin
        out_valid_d = bus.in_valid;
        data_out_d  = data_out_q;
        if (bus.in_valid) data_out_d = stage_word[SHW];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q <= 1'b0;
            data_out_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            data_out_q  <= data_out_d;
        end
    end

    assign bus.out_valid = out_valid_q;
    assign bus.data_out  = data_out_q;

endmodule

// File: tb/tb_barrel_shifter.sv
// Self-checking bench for barrel_shifter: directed vectors, then randomized traffic checked against an arithmetic model.
// Arithmetic-shift vectors are added when BARREL_SHIFTER_ARITH_EN is defined.
module tb_barrel_shifter;
    import barrel_shifter_pkg::*;

    localparam int W   = 4;
    localparam int SHW = $clog2(W);
`ifdef BARREL_SHIFTER_ARITH_EN
    localparam bit ARITH_ON = 1'b1;
`else
    localparam bit ARITH_ON = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] d;
        int           amt;
        logic         dr;
        logic         rot;
        logic [W-1:0] e;
    } vec_t;

    logic         clk;
    logic         rst;
    int           vectors     = 0;
    int           miscompares = 0;
    logic [W-1:0] exp_data;
    logic         exp_valid;

    barrel_shifter_if #(.WIDTH(W)) bus ();

    barrel_shifter #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not complete (observed timeout, required finish)");
        $fatal(1, "[TB] watchdog expired");
    end

    // Rotations use a doubled word; arithmetic right shifts use a signed shift.
    function automatic logic [W-1:0] model(input logic [W-1:0] d, input int k, input logic left,
                                           input logic rot, input logic ar);
        logic [2*W-1:0] dd;
        logic [2*W-1:0] t;
        dd = {d, d};
        if (rot) begin
            t = left ? (dd << k) : (dd >> k);
            return left ? t[2*W-1:W] : t[W-1:0];
        end
        if (left)             return d << k;
        if (ar && ARITH_ON)   return W'($signed(d) >>> k);
        return d >> k;
    endfunction

    task automatic applyStimulus(input logic r, input logic v, input logic [W-1:0] d, input int amt,
                                 input logic dr, input logic rot, input logic ar);
        @(negedge clk);
        rst           = r;
        bus.in_valid  = v;
        bus.data_in   = d;
        bus.shift_amt = SHW'(amt);
        bus.dir       = dr;
        bus.rotate    = rot;
`ifdef BARREL_SHIFTER_ARITH_EN
        bus.arith     = ar;
`endif
        if (r) begin
            exp_valid = 1'b0;
            exp_data  = '0;
        end else begin
            exp_valid = v;
            if (v) exp_data = model(d, amt, dr, rot, ar);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [W-1:0] req_data);
        @(posedge clk);
        #1;
        vectors++;
        assert (bus.out_valid === exp_valid) else begin
            miscompares++;
            $error("[TB] FAIL %s out_valid: observed %b expected %b", tag, bus.out_valid, exp_valid);
        end
        vectors++;
        assert (bus.data_out === req_data) else begin
            miscompares++;
            $error("[TB] FAIL %s data_out: observed %b expected %b", tag, bus.data_out, req_data);
        end
    endtask

    initial begin
        vec_t         directed [12];
        logic [W-1:0] d;
        logic         v;
        int           amt;
        logic         dr, rot, ar;

        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.data_in   = 4'b1010;
        bus.shift_amt = '0;
        bus.dir       = DIR_RIGHT;
        bus.rotate    = MODE_SHIFT;
`ifdef BARREL_SHIFTER_ARITH_EN
        bus.arith     = 1'b0;
`endif
        exp_valid     = 1'b0;
        exp_data      = '0;

        // Reset wins over an incoming valid operand.
        applyStimulus(1'b1, 1'b1, 4'b1010, 1, DIR_RIGHT, MODE_SHIFT, 1'b0);
        checkOutput("reset0", 4'b0000);
        applyStimulus(1'b1, 1'b1, 4'b1010, 1, DIR_RIGHT, MODE_SHIFT, 1'b0);
        checkOutput("reset1", 4'b0000);

        directed = '{
            '{4'b1010, 1, DIR_RIGHT, MODE_SHIFT,  4'b0101},
            '{4'b1010, 1, DIR_LEFT,  MODE_SHIFT,  4'b0100},
            '{4'b1010, 1, DIR_RIGHT, MODE_ROTATE, 4'b0101},
            '{4'b1010, 1, DIR_LEFT,  MODE_ROTATE, 4'b0101},
            '{4'b1010, 2, DIR_RIGHT, MODE_SHIFT,  4'b0010},
            '{4'b1010, 2, DIR_LEFT,  MODE_SHIFT,  4'b1000},
            '{4'b1010, 2, DIR_RIGHT, MODE_ROTATE, 4'b1010},
            '{4'b1010, 3, DIR_RIGHT, MODE_SHIFT,  4'b0001},
            '{4'b1010, 3, DIR_LEFT,  MODE_ROTATE, 4'b0101},
            '{4'b1111, 1, DIR_RIGHT, MODE_SHIFT,  4'b0111},
            '{4'b0011, 1, DIR_LEFT,  MODE_ROTATE, 4'b0110},
            '{4'b1100, 0, DIR_LEFT,  MODE_ROTATE, 4'b1100}
        };
        foreach (directed[i]) begin
            applyStimulus(1'b0, 1'b1, directed[i].d, directed[i].amt, directed[i].dr,
                          directed[i].rot, 1'b0);
            checkOutput($sformatf("directed%0d", i), directed[i].e);
        end

        // Every amount/direction/mode combination on one operand.
        for (int a = 0; a < W; a++) begin
            for (int m = 0; m < 4; m++) begin
                applyStimulus(1'b0, 1'b1, 4'b1001, a, m[0], m[1], 1'b0);
                checkOutput($sformatf("exh_amt%0d_dir%0d_rot%0d", a, m[0], m[1]), exp_data);
            end
        end

`ifdef BARREL_SHIFTER_ARITH_EN
        applyStimulus(1'b0, 1'b1, 4'b1010, 1, DIR_RIGHT, MODE_SHIFT, 1'b1);
        checkOutput("arith_1010_r1", 4'b1101);
        applyStimulus(1'b0, 1'b1, 4'b1010, 3, DIR_RIGHT, MODE_SHIFT, 1'b1);
        checkOutput("arith_1010_r3", 4'b1111);
        applyStimulus(1'b0, 1'b1, 4'b0110, 1, DIR_RIGHT, MODE_SHIFT, 1'b1);
        checkOutput("arith_0110_r1", 4'b0011);
        applyStimulus(1'b0, 1'b1, 4'b1010, 1, DIR_LEFT, MODE_SHIFT, 1'b1);
        checkOutput("arith_ignored_left", 4'b0100);
        applyStimulus(1'b0, 1'b1, 4'b1010, 1, DIR_RIGHT, MODE_ROTATE, 1'b1);
        checkOutput("arith_ignored_rot", 4'b0101);
`endif

        // Alternating valid: data_out must hold through the idle cycles.
        for (int c = 0; c < 6; c++) begin
            v   = (c % 2 == 0);
            d   = W'($urandom);
            amt = $urandom_range(0, W - 1);
            applyStimulus(1'b0, v, d, amt, 1'($urandom), 1'($urandom), 1'b0);
            checkOutput($sformatf("gap%0d", c), exp_data);
        end

        for (int n = 0; n < 200; n++) begin
            v   = ($urandom_range(0, 3) != 0);
            d   = W'($urandom);
            amt = $urandom_range(0, W - 1);
            dr  = 1'($urandom);
            rot = 1'($urandom);
            ar  = 1'($urandom);
            applyStimulus(1'b0, v, d, amt, dr, rot, ar);
            checkOutput($sformatf("rand%0d", n), exp_data);
        end

        applyStimulus(1'b1, 1'b1, 4'b1111, 0, DIR_RIGHT, MODE_SHIFT, 1'b0);
        checkOutput("reset_mid", 4'b0000);
        applyStimulus(1'b0, 1'b1, 4'b0001, 3, DIR_LEFT, MODE_SHIFT, 1'b0);
        checkOutput("post_reset_l3", 4'b1000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/barrel_shifter.md
Name: barrel_shifter

Overview:
- Parameterised logarithmic barrel shifter with registered output; one clock, synchronous active-high reset.
- Shifts or rotates a data word left or right by a runtime amount of 0..WIDTH-1 positions.
- Used as a datapath primitive, e.g. in ALU shift units and bit-field alignment ahead of downstream registers.

Parameters:
- WIDTH, 4, data word width in bits; power of two, ≥2.
- SHW, $clog2(WIDTH), width of the shift-amount field (derived, not overridden).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- in_valid  input  1  qualifies data_in/shift_amt/dir/rotate this cycle
- data_in  input  WIDTH  operand
- shift_amt  input  SHW  shift/rotate distance, 0..WIDTH-1
- dir  input  1  0 = right (toward LSB), 1 = left (toward MSB)
- rotate  input  1  0 = logical shift with zero fill, 1 = rotate (wrapped bits re-enter)
- out_valid  output  1  data_out holds a result from a valid input
- data_out  output  WIDTH  shifted/rotated result

Behaviour:
- Reset: on a rising clk edge with rst=1, data_out <= 0 and out_valid <= 0. Reset wins over in_valid on the same edge.
- Latency is exactly 1 cycle:
  - in_valid=1 at edge N gives the result on data_out and out_valid=1 after edge N.
  - in_valid=0 at an edge gives out_valid <= 0; data_out holds its previous value.
- No backpressure; a new result may be accepted every cycle.
- Logical right by k: data_out = data_in >> k, upper k bits zero.
- Logical left by k: data_out = data_in << k, lower k bits zero.
- Rotate right by k: bit i of data_out = data_in[(i+k) mod WIDTH].
- Rotate left by k: bit i of data_out = data_in[(i-k) mod WIDTH].
- shift_amt=0: data_out = data_in for every dir/rotate combination.
- shift_amt=WIDTH-1, logical: only one original bit survives, at the MSB or LSB.
- Rotate left by k equals rotate right by WIDTH-k, e.g. 4-bit rotl 3 == rotr 1.
- Structure: SHW cascaded mux stages, stage s shifting by 2^s when shift_amt[s]=1. The combinational path is fully determined by inputs, with no latches.
- Input X/Z handling is unspecified; all inputs are assumed driven whenever in_valid=1.

Optional Feature:
- Macro BARREL_SHIFTER_ARITH_EN.
- Defined:
  - Adds input port arith (1 bit).
  - When arith=1, rotate=0 and dir=0, vacated upper bits are filled with data_in[WIDTH-1] (sign extension) instead of zero.
  - arith is ignored for left shifts and for rotates.
- Not defined: the port is absent and all right logical shifts zero-fill.

Decomposition:
- Package barrel_shifter_pkg holds:
  - DIR_RIGHT=1'b0 and DIR_LEFT=1'b1
  - MODE_SHIFT=1'b0 and MODE_ROTATE=1'b1
  - a function computing the reference result, for use by the verification model
- One sub-module is natural: barrel_shifter_stage, parameterised by WIDTH and DIST.
  - Inputs: a word plus enable, dir, rotate (and arith when enabled).
  - Output: the word shifted/rotated by DIST when enabled, else passed through.
  - Top instantiates SHW stages, then the output register.

Test Plan:
- Reset: assert rst for 2 cycles with in_valid=1 and data_in=1010 → out_valid=0, data_out=0000 during reset.
- WIDTH=4, data_in=1010, each applied one cycle, result one cycle later:
  - log R1 → 0101
  - log L1 → 0100
  - rot R1 → 0101
  - rot L1 → 0101
  - log R2 → 0010
  - log L2 → 1000
  - rot R2 → 1010
  - log R3 → 0001
  - rot L3 → 0101
- Patterns:
  - 1111 log R1 → 0111
  - 0011 rot L1 → 0110
  - 1100 amt 0 rot L → 1100
- Exhaustive on data_in=1001 over all 16 amt/dir/rotate combos:
  - amt0 → 1001 (all four combos)
  - logR1 → 0100, rotR1 → 1100, logL1 → 0010, rotL1 → 0011
  - logR2 → 0010, rotR2 → 0110, logL2 → 0100, rotL2 → 0110
  - logR3 → 0001, rotR3 → 0011, logL3 → 1000, rotL3 → 1100
- Back-to-back and gaps: alternate in_valid 1/0 for 6 cycles → out_valid tracks in_valid delayed by one cycle; data_out holds during invalid cycles.
- With BARREL_SHIFTER_ARITH_EN: 1010 arith R1 → 1101, arith R3 → 1111, 0110 arith R1 → 0011.
